// File: rtl/dma_drr_scheduler_if.sv
// Downstream DMA request bundle of the DRR scheduler.
// One latched request, valid/ready handshake.
interface dma_drr_scheduler_if #(
  parameter int N_REGIONS_BITS = 2,
  parameter int LEN_BITS       = 28
);
  logic                      m_req_valid;
  logic                      m_req_ready;
  logic [N_REGIONS_BITS-1:0] m_req_vfid;
  logic [LEN_BITS-1:0]       m_req_len;
  logic                      m_req_ctl;

  modport master (
    output m_req_valid,
    output m_req_vfid,
    output m_req_len,
    output m_req_ctl,
    input  m_req_ready
  );

  modport slave (
    input  m_req_valid,
    input  m_req_vfid,
    input  m_req_len,
    input  m_req_ctl,
    output m_req_ready
  );
endinterface

// File: rtl/dma_drr_scheduler.sv
// Deficit-round-robin arbiter for the shared DMA request channel.
// Beat-weighted fairness plus a per-region in-flight cap.
module dma_drr_scheduler #(
  parameter int N_REGIONS       = 4,
  parameter int N_REGIONS_BITS  = 2,
  parameter int LEN_BITS        = 28,
  parameter int BEAT_LOG_BITS   = 6,
  parameter int QUANTUM_LOG     = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int OBITS = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [N_REGIONS-1:0][3:0]           weight,
  input  logic [N_REGIONS-1:0]                s_req_valid,
  output logic [N_REGIONS-1:0]                s_req_ready,
  input  logic [N_REGIONS-1:0][LEN_BITS-1:0]  s_req_len,
  input  logic [N_REGIONS-1:0]                s_req_ctl,
  dma_drr_scheduler_if.master                 m_req,
  input  logic                                cpl_valid,
  input  logic [N_REGIONS_BITS-1:0]           cpl_vfid,
  output logic [N_REGIONS-1:0][OBITS-1:0]     outstanding,
  output logic [31:0]                         grant_cnt,
  output logic                                cpl_err
);

  localparam int BLEN_BITS = LEN_BITS - BEAT_LOG_BITS;
  localparam int DBITS     = BLEN_BITS + 1;

  localparam logic [0:0] SEL   = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam logic [N_REGIONS_BITS-1:0] RR_LAST =
    N_REGIONS_BITS'(N_REGIONS - 1);
  localparam logic [OBITS-1:0] O_MAX = OBITS'(MAX_OUTSTANDING);

  logic [0:0]                state;
  logic [N_REGIONS_BITS-1:0] rr;
  logic [N_REGIONS_BITS-1:0] rr_next;
  logic [DBITS-1:0]          deficit [N_REGIONS];

  logic [3:0]          cur_w;
  logic [LEN_BITS-1:0] cur_len;
  logic [LEN_BITS-1:0] len_m1;
  logic [DBITS-1:0]    beats;
  logic [DBITS-1:0]    quantum;
  logic [DBITS:0]      refill_sum;
  logic                skip;
  logic                blocked;
  logic                take;
  logic                grant;
  logic [N_REGIONS-1:0] inc_vec;
  logic [N_REGIONS-1:0] dec_vec;

  always_comb begin
    cur_w   = weight[rr];
    cur_len = s_req_len[rr];
    len_m1  = cur_len - LEN_BITS'(1);
    beats   = (cur_len == '0) ? DBITS'(1)
            : DBITS'(len_m1 >> BEAT_LOG_BITS) + DBITS'(1);
    quantum    = DBITS'(cur_w) << QUANTUM_LOG;
    refill_sum = {1'b0, deficit[rr]} + {1'b0, quantum};
    skip    = (cur_w == 4'd0) || !s_req_valid[rr];
    blocked = !skip && (outstanding[rr] == O_MAX);
    take    = !skip && !blocked && (deficit[rr] >= beats);
    grant   = (state == SEL) && take;
    rr_next = (rr == RR_LAST) ? '0 : rr + N_REGIONS_BITS'(1);
    s_req_ready = '0;
    if (grant && !areset) s_req_ready[rr] = 1'b1;
    inc_vec = '0;
    if (grant) inc_vec[rr] = 1'b1;
    dec_vec = '0;
    if (cpl_valid) dec_vec[cpl_vfid] = 1'b1;
  end

  assign m_req.m_req_valid = (state == ISSUE);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= SEL;
      rr        <= '0;
      grant_cnt <= '0;
      m_req.m_req_vfid <= '0;
      m_req.m_req_len  <= '0;
      m_req.m_req_ctl  <= 1'b0;
      for (int i = 0; i < N_REGIONS; i++) deficit[i] <= '0;
    end else if (state == ISSUE) begin
      if (m_req.m_req_ready) state <= SEL;
    end else begin
      unique case (1'b1)
        skip: begin
          deficit[rr] <= '0;
          rr          <= rr_next;
        end
        blocked: rr <= rr_next;
        take: begin
          deficit[rr]      <= deficit[rr] - beats;
          m_req.m_req_vfid <= rr;
          m_req.m_req_len  <= cur_len;
          m_req.m_req_ctl  <= s_req_ctl[rr];
          grant_cnt        <= grant_cnt + 32'd1;
          state            <= ISSUE;
        end
        default: begin
          // quantum refill saturates instead of wrapping
          deficit[rr] <= refill_sum[DBITS] ? '1
                       : refill_sum[DBITS-1:0];
          rr <= rr_next;
        end
      endcase
    end
  end

  // a grant and a completion on one region cancel out
  always_ff @(posedge aclk) begin
    if (areset) begin
      outstanding <= '0;
      cpl_err     <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          outstanding[i] <= outstanding[i] + OBITS'(1);
        end else if (dec_vec[i] && !inc_vec[i]) begin
          if (outstanding[i] == '0) cpl_err <= 1'b1;
          else outstanding[i] <= outstanding[i] - OBITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_drr_scheduler.sv
// Self-checking bench for dma_drr_scheduler.
// Transaction-level DRR reference model with randomized traffic.
module tb_dma_drr_scheduler;

  localparam int NR   = 4;
  localparam int MAXO = 8;
  localparam longint DMAX = (64'd1 << 23) - 1;

  logic              aclk = 1'b0;
  logic              areset;
  logic [3:0][3:0]   weight;
  logic [3:0]        s_req_valid;
  logic [3:0]        s_req_ready;
  logic [3:0][27:0]  s_req_len;
  logic [3:0]        s_req_ctl;
  logic              cpl_valid;
  logic [1:0]        cpl_vfid;
  logic [3:0][3:0]   outstanding;
  logic [31:0]       grant_cnt;
  logic              cpl_err;

  dma_drr_scheduler_if #(
    .N_REGIONS_BITS(2),
    .LEN_BITS(28)
  ) m_req ();

  dma_drr_scheduler dut (
    .aclk(aclk),
    .areset(areset),
    .weight(weight),
    .s_req_valid(s_req_valid),
    .s_req_ready(s_req_ready),
    .s_req_len(s_req_len),
    .s_req_ctl(s_req_ctl),
    .m_req(m_req),
    .cpl_valid(cpl_valid),
    .cpl_vfid(cpl_vfid),
    .outstanding(outstanding),
    .grant_cnt(grant_cnt),
    .cpl_err(cpl_err)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  int          m_rr;
  longint      m_def [NR];
  int          m_out [NR];
  bit          m_err;
  logic [31:0] m_gcnt;
  bit          m_issue;
  int          m_g;
  logic [27:0] m_len;
  bit          m_ctl;
  bit          regen;

  logic [3:0]  exp_ready, obs_ready;
  logic        exp_valid, obs_valid;
  logic [1:0]  exp_vfid, obs_vfid;
  logic [27:0] exp_len, obs_len;
  logic        exp_ctl, obs_ctl;

  function automatic longint beats_of(input logic [27:0] len);
    if (len == 0) return 1;
    return (longint'(len) + 63) / 64;
  endfunction

  function automatic logic [27:0] rand_len();
    case ($urandom_range(0, 3))
      0: return 28'd0;
      1: return 28'($urandom_range(1, 64));
      2: return 28'($urandom_range(65, 4096));
      default: return 28'($urandom_range(4097, 65536));
    endcase
  endfunction

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < NR; i++) begin
      m_def[i] = 0;
      m_out[i] = 0;
    end
    m_err = 0;
    m_gcnt = 0;
    m_issue = 0;
    m_g = 0;
    m_len = 0;
    m_ctl = 0;
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    m_req.m_req_ready = 1'b0;
    cpl_valid = 1'b0;
    cpl_vfid = 2'd0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    model_reset();
  endtask

  // one clock: drive, sample, advance model by the DRR rules
  task automatic step(input bit rdy, input bit cv, input int cf);
    int g;
    int r;
    longint b;
    m_req.m_req_ready = rdy;
    cpl_valid = cv;
    cpl_vfid = 2'(cf);
    #1;
    obs_ready = s_req_ready;
    obs_valid = m_req.m_req_valid;
    obs_vfid  = m_req.m_req_vfid;
    obs_len   = m_req.m_req_len;
    obs_ctl   = m_req.m_req_ctl;
    exp_ready = '0;
    exp_valid = m_issue;
    exp_vfid  = 2'(m_g);
    exp_len   = m_len;
    exp_ctl   = m_ctl;
    g = -1;
    if (!m_issue) begin
      r = m_rr;
      b = beats_of(s_req_len[r]);
      if (weight[r] == 0 || !s_req_valid[r]) begin
        m_def[r] = 0;
        m_rr = (r + 1) % NR;
      end else if (m_out[r] == MAXO) begin
        m_rr = (r + 1) % NR;
      end else if (m_def[r] >= b) begin
        g = r;
        m_def[r] -= b;
        exp_ready[r] = 1'b1;
        m_issue = 1;
        m_g = r;
        m_len = s_req_len[r];
        m_ctl = s_req_ctl[r];
        m_gcnt++;
      end else begin
        m_def[r] += 16 * longint'(weight[r]);
        if (m_def[r] > DMAX) m_def[r] = DMAX;
        m_rr = (r + 1) % NR;
      end
    end else if (rdy) begin
      m_issue = 0;
    end
    if (g >= 0) m_out[g]++;
    if (cv) begin
      if (m_out[cf] == 0) m_err = 1;
      else m_out[cf]--;
    end
    @(posedge aclk);
    #1;
    cpl_valid = 1'b0;
    if (g >= 0 && regen) begin
      s_req_len[g]   = rand_len();
      s_req_ctl[g]   = 1'($urandom_range(0, 1));
      s_req_valid[g] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin
      weight[i] = 4'hF;
      s_req_len[i] = 28'd64;
    end
    s_req_valid = '1;
    s_req_ctl = '1;
    cpl_valid = 1'b1;
    cpl_vfid = 2'd1;
    m_req.m_req_ready = 1'b1;
    areset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge aclk);
      #1;
      vectors++;
      if (s_req_ready !== 4'b0 || m_req.m_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hs cyc=%0d got rdy=%b vld=%b want 0",
                 c, s_req_ready, m_req.m_req_valid);
      end
    end
    vectors++;
    if (m_req.m_req_vfid !== 2'd0 || m_req.m_req_len !== 28'd0 ||
        m_req.m_req_ctl !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_payload got %0d/%0d/%b want 0",
               m_req.m_req_vfid, m_req.m_req_len, m_req.m_req_ctl);
    end
    vectors++;
    if (outstanding !== '0 || grant_cnt !== 32'd0 ||
        cpl_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cnt got out=%h gc=%0d err=%b want 0",
               outstanding, grant_cnt, cpl_err);
    end
    cpl_valid = 1'b0;
  endtask

  task automatic test_single();
    int first;
    first = 0;
    regen = 0;
    weight = '0;
    weight[0] = 4'd1;
    s_req_valid = 4'b0001;
    for (int i = 0; i < NR; i++) s_req_len[i] = 28'd64;
    s_req_ctl = 4'b0001;
    apply_reset();
    for (int c = 1; c <= 60; c++) begin
      step(1'b1, m_issue, 0);
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL single_hs cyc=%0d got %b/%b want %b/%b",
                 c, obs_ready, obs_valid, exp_ready, exp_valid);
      end
      if (obs_ready != 0 && first == 0) first = c;
      if (obs_valid) begin
        vectors++;
        if (obs_vfid !== 2'd0 || obs_len !== 28'd64 ||
            obs_ctl !== 1'b1) begin
          miscompares++;
          $display("FAIL single_payload got %0d/%0d/%b want 0/64/1",
                   obs_vfid, obs_len, obs_ctl);
        end
      end
    end
    vectors++;
    if (first != 5) begin
      miscompares++;
      $display("FAIL single_first got cyc %0d want 5", first);
    end
    vectors++;
    if (grant_cnt !== 32'd26) begin
      miscompares++;
      $display("FAIL single_grants got %0d want 26", grant_cnt);
    end
  endtask

  task automatic test_weights();
    int cnt0, cnt1, cyc;
    cnt0 = 0;
    cnt1 = 0;
    cyc = 0;
    weight = '0;
    weight[0] = 4'd2;
    weight[1] = 4'd1;
    s_req_valid = 4'b0011;
    for (int i = 0; i < NR; i++) s_req_len[i] = 28'd1024;
    apply_reset();
    while (cnt0 + cnt1 < 300 && cyc < 3000) begin
      step(1'b1, m_issue, m_g);
      cyc++;
      if (obs_ready[0]) cnt0++;
      if (obs_ready[1]) cnt1++;
      vectors++;
      if (obs_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL weights_ready cyc=%0d got %b want %b",
                 cyc, obs_ready, exp_ready);
      end
    end
    vectors++;
    if (cyc >= 3000) begin
      miscompares++;
      $display("FAIL weights_timeout got %0d grants want 300",
               cnt0 + cnt1);
    end
    vectors++;
    if (cnt0 < 198 || cnt0 > 202 || cnt1 < 98 || cnt1 > 102) begin
      miscompares++;
      $display("FAIL weights_ratio got %0d:%0d want 200:100",
               cnt0, cnt1);
    end
  endtask

  task automatic test_outstanding();
    weight = '0;
    weight[0] = 4'd15;
    s_req_valid = 4'b0001;
    s_req_len[0] = 28'd64;
    apply_reset();
    repeat (80) begin
      step(1'b1, 1'b0, 0);
      vectors++;
      if (obs_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL ostd_ready got %b want %b", obs_ready, exp_ready);
      end
    end
    vectors++;
    if (outstanding[0] !== 4'd8 || grant_cnt !== 32'd8) begin
      miscompares++;
      $display("FAIL ostd_cap got out=%0d gc=%0d want 8/8",
               outstanding[0], grant_cnt);
    end
    step(1'b0, 1'b1, 0);
    repeat (40) step(1'b1, 1'b0, 0);
    vectors++;
    if (outstanding[0] !== 4'd8 || grant_cnt !== 32'd9) begin
      miscompares++;
      $display("FAIL ostd_release got out=%0d gc=%0d want 8/9",
               outstanding[0], grant_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [27:0] g_len;
    logic        g_ctl;
    weight = '0;
    weight[2] = 4'd3;
    s_req_valid = 4'b0100;
    s_req_len[2] = 28'($urandom_range(1, 4095));
    s_req_ctl[2] = 1'($urandom_range(0, 1));
    g_len = s_req_len[2];
    g_ctl = s_req_ctl[2];
    apply_reset();
    n = 0;
    while (!m_issue && n < 50) begin
      step(1'b0, 1'b0, 0);
      n++;
    end
    vectors++;
    if (!m_issue) begin
      miscompares++;
      $display("FAIL bp_grant_timeout got none want grant");
    end
    for (int k = 0; k < 10; k++) begin
      s_req_len[2] = rand_len();
      s_req_valid = '1;
      step(1'b0, 1'b0, 0);
      vectors++;
      if (obs_valid !== 1'b1 || obs_vfid !== 2'd2 ||
          obs_len !== g_len || obs_ctl !== g_ctl ||
          obs_ready !== 4'b0 || grant_cnt !== 32'd1) begin
        miscompares++;
        $display("FAIL bp_hold k=%0d got %b/%0d/%0d/%b/%b/%0d",
                 k, obs_valid, obs_vfid, obs_len, obs_ctl,
                 obs_ready, grant_cnt);
      end
    end
    step(1'b1, 1'b0, 0);
    n = 0;
    while (!m_issue && n < 50) begin
      step(1'b0, 1'b0, 0);
      n++;
    end
    areset = 1'b1;
    @(posedge aclk);
    #1;
    vectors++;
    if (m_req.m_req_valid !== 1'b0 || m_req.m_req_len !== 28'd0) begin
      miscompares++;
      $display("FAIL bp_reset_drop got vld=%b len=%0d want 0/0",
               m_req.m_req_valid, m_req.m_req_len);
    end
    areset = 1'b0;
    model_reset();
  endtask

  task automatic test_cpl();
    int n;
    weight = '0;
    s_req_valid = '0;
    apply_reset();
    step(1'b0, 1'b1, 2);
    vectors++;
    if (cpl_err !== 1'b1 || outstanding[2] !== 4'd0) begin
      miscompares++;
      $display("FAIL cpl_err_set got err=%b out=%0d want 1/0",
               cpl_err, outstanding[2]);
    end
    repeat (5) step(1'b0, 1'b0, 0);
    weight[1] = 4'd15;
    s_req_valid = 4'b0010;
    s_req_len[1] = 28'd64;
    n = 0;
    while (!(m_gcnt == 3 && !m_issue) && n < 100) begin
      step(1'b1, 1'b0, 0);
      n++;
    end
    step(1'b1, 1'b1, 1);
    vectors++;
    if (obs_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL cpl_same_grant got %b want 0010", obs_ready);
    end
    vectors++;
    if (outstanding[1] !== 4'd3 || grant_cnt !== 32'd4 ||
        cpl_err !== 1'b1) begin
      miscompares++;
      $display("FAIL cpl_same_cnt got out=%0d gc=%0d err=%b want 3/4/1",
               outstanding[1], grant_cnt, cpl_err);
    end
    apply_reset();
    vectors++;
    if (cpl_err !== 1'b0) begin
      miscompares++;
      $display("FAIL cpl_err_clear got %b want 0", cpl_err);
    end
  endtask

  task automatic test_random();
    int r;
    regen = 1;
    for (int i = 0; i < NR; i++) begin
      weight[i] = ($urandom_range(0, 7) == 0) ? 4'd0
                : 4'($urandom_range(1, 15));
      s_req_valid[i] = 1'($urandom_range(0, 1));
      s_req_len[i] = rand_len();
      s_req_ctl[i] = 1'($urandom_range(0, 1));
    end
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, NR - 1);
        weight[r] = 4'($urandom_range(0, 15));
        s_req_valid[r] = 1'($urandom_range(0, 1));
        s_req_len[r] = rand_len();
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
           $urandom_range(0, NR - 1));
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL rnd_hs cyc=%0d got %b/%b want %b/%b",
                 c, obs_ready, obs_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_vfid !== exp_vfid || obs_len !== exp_len ||
            obs_ctl !== exp_ctl) begin
          miscompares++;
          $display("FAIL rnd_payload cyc=%0d got %0d/%0d/%b want %0d/%0d/%b",
                   c, obs_vfid, obs_len, obs_ctl,
                   exp_vfid, exp_len, exp_ctl);
        end
      end
      for (int i = 0; i < NR; i++) begin
        vectors++;
        if (outstanding[i] !== 4'(m_out[i])) begin
          miscompares++;
          $display("FAIL rnd_ostd cyc=%0d r=%0d got %0d want %0d",
                   c, i, outstanding[i], m_out[i]);
        end
      end
      vectors++;
      if (grant_cnt !== m_gcnt || cpl_err !== m_err) begin
        miscompares++;
        $display("FAIL rnd_cnt cyc=%0d got gc=%0d err=%b want %0d/%b",
                 c, grant_cnt, cpl_err, m_gcnt, m_err);
      end
    end
    regen = 0;
  endtask

  initial begin
    areset = 1'b1;
    weight = '0;
    s_req_valid = '0;
    s_req_len = '0;
    s_req_ctl = '0;
    cpl_valid = 1'b0;
    cpl_vfid = 2'd0;
    m_req.m_req_ready = 1'b0;
    regen = 0;
    model_reset();
    test_reset();
    test_single();
    test_weights();
    test_outstanding();
    test_backpressure();
    test_cpl();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
